// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Stalls the pipeline while busy and pulses done with the result.
module muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            pause,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int CMAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [1:0]      op_f;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;

  // Accept-time decode, from the live operands
  logic            div_signed;
  logic            is_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            b_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] spec_res;

  assign div_signed = ~func3[0];
  assign is_rem     = func3[1];
  assign a_neg      = div_signed & a[XLEN-1];
  assign b_neg      = div_signed & b[XLEN-1];
  assign mag_a      = a_neg ? -a : a;
  assign mag_b      = b_neg ? -b : b;
  assign b_zero     = (b == '0);
  assign ovf        = div_signed & (a == MIN) & (b == '1);
  assign special    = func3[2] & (b_zero | ovf);

  always_comb begin
    spec_res = '0;
    if (b_zero)
      spec_res = is_rem ? a : '1;
    else if (ovf)
      spec_res = is_rem ? '0 : a;
  end

  // Multiply: sign/zero-extend to 2*XLEN, truncated product
  logic              sa;
  logic              sb;
  logic [2*XLEN-1:0] xa;
  logic [2*XLEN-1:0] xb;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  assign sa      = op_a[XLEN-1] & (op_f[1] ^ op_f[0]);
  assign sb      = op_b[XLEN-1] & (op_f == 2'b01);
  assign xa      = {{XLEN{sa}}, op_a};
  assign xb      = {{XLEN{sb}}, op_b};
  assign prod    = xa * xb;
  assign mul_res = (op_f == 2'b00) ? prod[XLEN-1:0]
                                   : prod[2*XLEN-1:XLEN];

  // Restoring division step on magnitudes
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] div_res;

  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs};
  assign fits    = ~diff[XLEN];
  assign rem_nx  = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_nx  = {quo[XLEN-2:0], fits};
  assign neg_q   = ~op_f[0] & (op_a[XLEN-1] ^ op_b[XLEN-1]);
  assign neg_r   = ~op_f[0] & op_a[XLEN-1];

  always_comb begin
    div_res = quo_nx;
    if (op_f[1])
      div_res = neg_r ? -rem_nx : rem_nx;
    else if (neg_q)
      div_res = -quo_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_f   <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a <= a;
            op_b <= b;
            op_f <= func3[1:0];
            if (!func3[2]) begin
              state <= MUL;
              cnt   <= CW'(MUL_LATENCY - 1);
            end else if (special) begin
              state  <= DONE;
              result <= spec_res;
            end else begin
              state <= DIV;
              cnt   <= CW'(XLEN - 1);
              quo   <= mag_a;
              rem   <= '0;
              dvs   <= mag_b;
            end
          end
        end
        MUL: begin
          if (cnt == '0) begin
            result <= mul_res;
            state  <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          quo <= quo_nx;
          rem <= rem_nx;
          if (cnt == '0) begin
            result <= div_res;
            state  <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign pause = start & ~done & ~flush;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an arithmetic reference model.
// Checks latency, handshake outputs, flush and async reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        pause;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  bit          track = 1'b0;
  int          cyc = 0;
  int          exp_n = 0;
  logic [31:0] exp_res = '0;
  logic [31:0] last_res = '0;

  muldiv_unit #(.XLEN(32), .MUL_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3),
    .a(a), .b(b), .flush(flush), .pause(pause),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx;
    longint sy;
    longint ux;
    longint uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    p = '0;
    case (f)
      3'd0: begin p = 64'(ux * uy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = 64'(ux * uy); return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = 64'(sx / sy);
        return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sx % sy);
        return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    if (!f[2]) return 3;
    if (y == 0) return 1;
    if (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Cycle-by-cycle compare against the expected timeline
  always @(negedge clk) begin
    if (track) begin
      chk("done", {31'b0, done}, {31'b0, cyc == exp_n});
      chk("pause", {31'b0, pause}, {31'b0, cyc < exp_n});
      chk("busy", {31'b0, busy}, {31'b0, cyc >= 1 && cyc <= exp_n});
      if (cyc == exp_n)
        chk("result", result, exp_res);
    end
  end

  task automatic run(input logic [2:0] f,
                     input logic [31:0] x,
                     input logic [31:0] y,
                     input logic [31:0] lit);
    bit got;
    chk("model_pin", model(f, x, y), lit);
    @(posedge clk);
    #1;
    start   = 1'b1;
    func3   = f;
    a       = x;
    b       = y;
    exp_res = lit;
    exp_n   = latency(f, x, y);
    cyc     = 0;
    track   = 1'b1;
    @(posedge clk);
    #1;
    a = $urandom;
    b = $urandom;
    got = 1'b0;
    for (int k = 0; k < exp_n + 3; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      miscompares++;
      $display("FAIL timeout: no done for func3=%0d, expected cycle %0d",
               f, exp_n);
    end
    @(posedge clk);
    #1;
    track = 1'b0;
    start = 1'b0;
    last_res = lit;
    @(negedge clk);
    chk("idle_after_done", {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    func3 = '0;
    a     = '0;
    b     = '0;
    flush = 1'b0;
    #3;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_pause", {31'b0, pause}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    run(3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run(3'd5, 32'd100, 32'd7, 32'd14);
    run(3'd7, 32'd100, 32'd7, 32'd2);
    run(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run(3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1);
    run(3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run(3'd7, 32'hFFFF_FFFF, 32'd10, 32'd5);
    run(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run(3'd6, 32'd5, 32'd0, 32'd5);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush at cycle 10 of a DIV
    @(posedge clk);
    #1;
    start = 1'b1;
    func3 = 3'd4;
    a = 32'hFFFF_FFF9;
    b = 32'd2;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_pause", {31'b0, pause}, 32'd0);
    chk("flush_busy_c10", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) chk("flush_busy_c11", {31'b0, busy}, 32'd0);
      if (done) chk("flush_no_done", 32'd1, 32'd0);
    end
    chk("flush_result", result, last_res);
    run(3'd0, 32'd3, 32'd4, 32'd12);

    // Async reset between edges in the middle of a DIV
    @(posedge clk);
    #1;
    start = 1'b1;
    func3 = 3'd5;
    a = 32'd1000;
    b = 32'd3;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    start = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) chk("arst_quiet", {30'b0, busy, done}, 32'd0);
    end
    run(3'd7, 32'd100, 32'd7, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit for the EX stage of the five-stage pipeline. It is parametrised in operand width and multiply latency. It accepts one M-extension operation at a time, holds the pipeline with a combinational stall while it works, and returns the result with a one-cycle `done` pulse. It honours the pipeline `flush` so that wrong-path operations are cancelled.

## Interface
- `XLEN`, 32, operand/result width (≥ 8, even)
- `MUL_LATENCY`, 2, cycles spent in MUL state (≥ 1)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  EX holds an M-extension op; held high until `done`
- `func3`  in  3  RV32M func3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `a`  in  XLEN  rs1 operand (post-forwarding)
- `b`  in  XLEN  rs2 operand (post-forwarding)
- `flush`  in  1  cancel in-flight op (control hazard)
- `pause`  out  1  stall request to PC/IF_ID/ID_EX = `start & ~done & ~flush`, combinational
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle
- `result`  out  XLEN  operation result; holds its last value until the next DONE

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE, `start` & ~`flush`: capture `a`, `b`, and `func3`, then:
  - func3[2]=0 → MUL; counter = MUL_LATENCY-1.
  - func3[2]=1 and special case → DONE, with the special result loaded.
  - otherwise → DIV; counter = XLEN-1.
- MUL: computes the 2·XLEN-bit product of the operands sign/zero-extended per func3.
  - MULH: s×s. MULHSU: s×u. MULHU: u×u.
  - MUL takes the low XLEN bits; the others take the high XLEN bits.
  - Counter decrements each cycle; at 0 the result is registered and the state goes to DONE.
- DIV: restoring division on operand magnitudes, one quotient bit per cycle, XLEN cycles.
  - Signed ops: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - At counter 0 the state goes to DONE; the result is the quotient (100/101) or remainder (110/111).
- Special cases, resolved at accept:
  - b == 0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (DIV/REM, a = 1<<(XLEN-1), b = all ones): DIV → a; REM → 0.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` seen in DONE is ignored, because it belongs to the instruction that is leaving EX.
- `flush` in any state: next edge → IDLE, no `done`, `result` unchanged. `flush` takes priority over `start` in the same cycle.
- Ops with rd = x0 are still executed; discarding the result is the writeback path's job.

## Timing
- Reset (async, immediate): state IDLE, counter 0, `busy` 0, `done` 0, `result` 0, operand registers 0. `pause` follows its equation (it is 0 while `start` is low).
- Accept edge = end of cycle 0; `busy` rises in cycle 1.
- Latency from accept to `done` (done in cycle N):
  - MUL ops: N = MUL_LATENCY+1.
  - Divide ops: N = XLEN+1.
  - Special cases: N = 1.
- `pause` is high from cycle 0 through cycle N-1 and low in cycle N, so the pipeline advances on the edge that ends the `done` cycle.
- Back-to-back: a new `start` in cycle N+1 (IDLE) is accepted; throughput is one op per N+1 cycles.
- Reset asserted mid-operation: immediate IDLE; no `done` is issued afterwards.
- `a`/`b` changes after accept have no effect, because the operands are registered.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3), MUL_LATENCY=2 → `done` in cycle 3, `result`=0xFFFFFFEB; `pause` high in cycles 0–2.
- MULH a=b=0x80000000 → 0x40000000. MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (−7), b=2 → `done` in cycle 33, `result`=0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases:
  - DIVU 5/0 → `done` in cycle 1, 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- `flush` at cycle 10 of a DIV → IDLE at cycle 11, no `done` pulse, `result` keeps its prior value; a following MUL 3×4 → 12 at the correct latency.
- `rst` pulsed mid-DIV (asynchronous, between edges) → `busy`/`done`/`result` = 0 immediately; a `start` held high in DONE is not re-accepted.
